// File: rtl/pdu_ctrl.sv
// Debug/program-download controller: gates the CPU clock enable for step/run/breakpoint,
// services keypad IO handshakes and shows registers, memory and counters on the display.
module pdu_ctrl #(
   parameter int AW    = 32,
   parameter int RFAW  = 8,
   parameter int N_BRK = 4,
   localparam int IW   = (N_BRK > 1) ? $clog2(N_BRK) : 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            step,
   input  logic            cont,
   input  logic            chk,
   input  logic            ent,
   input  logic            del,
   input  logic [15:0]     hd,
   input  logic            brk_set,
   input  logic            brk_clr,
   input  logic [IW-1:0]   brk_idx,
   input  logic [AW-1:0]   pc,
   input  logic [AW-1:0]   rf_data,
   input  logic [AW-1:0]   m_data,
   input  logic            io_we,
   input  logic            io_rd,
   input  logic [AW-1:0]   io_dout,
   output logic [AW-1:0]   io_din,
   output logic            cpu_en,
   output logic            pause,
   output logic [RFAW-1:0] m_rf_addr,
   output logic [AW-1:0]   show,
   output logic [15:0]     led,
   output logic [AW-1:0]   run_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STEP,
      S_RUN,
      S_CHK,
      S_OUT,
      S_IN,
      S_RESUME
   } state_t;

   state_t          r_state;
   state_t          w_nxt;
   logic            r_first;
   logic            r_from_run;
   logic [AW-1:0]   r_ent;
   logic [AW-1:0]   r_out;
   logic [AW-1:0]   r_io_din;
   logic [AW-1:0]   r_chk_show;
   logic [AW-1:0]   r_run_cnt;
   logic [3:0]      r_mode;
   logic [RFAW-1:0] r_rf_addr;
   logic [AW-1:0]   r_brk_addr [N_BRK];
   logic [N_BRK-1:0] r_brk_en;

   logic            w_cpu_en;
   logic            w_bp_hit;
   logic [3:0]      w_dig;
   logic [AW-1:0]   w_show;
   logic [15:0]     w_led;

   // Lowest pressed key wins when several bits are set.
   always_comb begin
      w_dig = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (hd[i]) w_dig = 4'(i);
      end
   end

   always_comb begin
      w_bp_hit = 1'b0;
      for (int k = 0; k < N_BRK; k++) begin
         if (r_brk_en[k] && (r_brk_addr[k] == pc)) w_bp_hit = 1'b1;
      end
   end

   always_comb begin
      w_nxt    = r_state;
      w_cpu_en = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_we)      w_nxt = S_OUT;
            else if (io_rd) w_nxt = S_IN;
            else if (chk)   w_nxt = S_CHK;
            else if (step)  w_nxt = S_STEP;
            else if (cont)  w_nxt = S_RUN;
         end
         S_STEP: begin
            w_cpu_en = 1'b1;
            w_nxt    = S_IDLE;
         end
         S_RUN: begin
            // The first cycle skips the breakpoint so cont leaves a breakpoint pc.
            if (cont)                       w_nxt = S_IDLE;
            else if (io_we)                 w_nxt = S_OUT;
            else if (io_rd)                 w_nxt = S_IN;
            else if (w_bp_hit && !r_first)  w_nxt = S_IDLE;
            w_cpu_en = (w_nxt == S_RUN);
         end
         S_CHK: begin
            if (ent) w_nxt = S_IDLE;
         end
         S_OUT, S_IN: begin
            if (ent) w_nxt = S_RESUME;
         end
         S_RESUME: begin
            w_cpu_en = 1'b1;
            w_nxt    = r_from_run ? S_RUN : S_IDLE;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_show = r_ent;
      w_led  = pc[15:0];
      case (r_state)
         S_CHK: begin
            w_show = r_chk_show;
            w_led  = {12'b0, r_mode};
         end
         S_OUT: begin
            w_show = r_out;
            w_led  = r_out[15:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_first    <= 1'b0;
         r_from_run <= 1'b0;
         r_ent      <= '0;
         r_out      <= '0;
         r_io_din   <= '0;
         r_chk_show <= '0;
         r_run_cnt  <= '0;
         r_mode     <= '0;
         r_rf_addr  <= '0;
         r_brk_en   <= '0;
         for (int k = 0; k < N_BRK; k++) r_brk_addr[k] <= '0;
      end else begin
         r_state <= w_nxt;
         r_first <= (w_nxt == S_RUN) && (r_state != S_RUN);

         if (del)
            r_ent <= r_ent >> 4;
         else if (hd != 16'd0)
            r_ent <= {r_ent[AW-5:0], w_dig};

         if ((w_nxt == S_OUT || w_nxt == S_IN) && (r_state == S_IDLE || r_state == S_RUN))
            r_from_run <= (r_state == S_RUN);
         if (w_nxt == S_OUT && r_state != S_OUT)
            r_out <= io_dout;
         if (r_state == S_IN && ent)
            r_io_din <= r_ent;

         if (w_cpu_en)
            r_run_cnt <= r_run_cnt + AW'(1);

         if (r_state == S_IDLE && w_nxt == S_CHK) begin
            r_mode    <= r_ent[15:12];
            r_rf_addr <= r_ent[RFAW-1:0];
         end else if (r_state == S_CHK) begin
            if (chk) begin
               case (r_mode)
                  4'd1: r_chk_show <= pc;
                  4'd2: begin
                     r_chk_show <= rf_data;
                     r_rf_addr  <= r_rf_addr + RFAW'(1);
                  end
                  4'd3: begin
                     r_chk_show <= m_data;
                     r_rf_addr  <= r_rf_addr + RFAW'(1);
                  end
                  4'd4: r_chk_show <= r_run_cnt;
                  default: ;
               endcase
            end
            if (step)
               r_rf_addr <= r_ent[RFAW-1:0];
         end

         if (brk_clr) begin
            r_brk_en <= '0;
         end else if (brk_set) begin
            for (int k = 0; k < N_BRK; k++) begin
               if (brk_idx == IW'(k)) begin
                  r_brk_addr[k] <= r_ent;
                  r_brk_en[k]   <= 1'b1;
               end
            end
         end
      end
   end

   assign cpu_en    = w_cpu_en;
   assign pause     = !(r_state == S_STEP || r_state == S_RUN || r_state == S_RESUME);
   assign show      = w_show;
   assign led       = w_led;
   assign io_din    = r_io_din;
   assign m_rf_addr = r_rf_addr;
   assign run_cnt   = r_run_cnt;

endmodule
